// File: rtl/mmio_router.sv
// Memory-mapped router between the core data port and NUM_SLAVES peripherals.
// One outstanding request; timeout produces an error response and bumps a counter.
module mmio_router #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_MSB = 31,
  parameter int unsigned SEL_LSB = 28,
  parameter logic [NUM_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLAVE_LIMITS = {4'h8, 4'h3, 4'h2, 4'h0},
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             m_en_i,
  input  logic [DATA_WIDTH/8-1:0]          m_we_i,
  input  logic [ADDR_WIDTH-1:0]            m_addr_i,
  input  logic [DATA_WIDTH-1:0]            m_data_i,
  output logic                             m_gnt_o,
  output logic                             m_ready_o,
  output logic                             m_err_o,
  output logic [DATA_WIDTH-1:0]            m_data_o,
  output logic [NUM_SLAVES-1:0]            s_en_o,
  output logic [DATA_WIDTH/8-1:0]          s_we_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic [DATA_WIDTH-1:0]            s_data_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]            s_ready_i,
  output logic [15:0]                      err_count_o
);

  localparam int unsigned SW = SEL_MSB - SEL_LSB + 1;
  localparam int unsigned IW = $clog2(NUM_SLAVES);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     err_q, err_d;
  logic [IW-1:0]   dec;
  logic [SW-1:0]   field;

  // Ascending limits: the highest slave whose limit is <= field wins; limit[0] unused.
  always_comb begin
    field = m_addr_i[SEL_MSB:SEL_LSB];
    dec   = '0;
    for (int unsigned i = 1; i < NUM_SLAVES; i++) begin
      if (field >= SLAVE_LIMITS[i*SW +: SW]) dec = IW'(i);
    end
  end

  assign s_we_o      = m_we_i;
  assign s_addr_o    = m_addr_i;
  assign s_data_o    = m_data_i;
  assign err_count_o = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      timer_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    err_d     = err_q;
    m_gnt_o   = 1'b0;
    m_ready_o = 1'b0;
    m_err_o   = 1'b0;
    m_data_o  = '0;
    s_en_o    = '0;

    unique case (state_q)
      IDLE: m_gnt_o = 1'b1;
      WAIT: begin
        if (s_ready_i[sel_q]) begin
          m_ready_o = 1'b1;
          m_data_o  = s_data_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
          m_gnt_o   = 1'b1;
          state_d   = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          m_ready_o = 1'b1;
          m_err_o   = 1'b1;
          m_gnt_o   = 1'b1;
          state_d   = IDLE;
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept overrides the response-cycle return to IDLE for back-to-back requests.
    if (m_gnt_o && m_en_i) begin
      s_en_o[dec] = 1'b1;
      sel_d       = dec;
      timer_d     = '0;
      state_d     = WAIT;
    end

    if (!reset) begin
      m_gnt_o = 1'b0;
      s_en_o  = '0;
    end
  end

endmodule
